// File: rtl/dcache_pkg.sv
// Shared dcache widths and the writeback engine state encoding.
package dcache_pkg;

    localparam int INDEX_W    = 6;
    localparam int WAY_W      = 3;
    localparam int OFFSET_W   = 2;
    localparam int LINE_BEATS = 4;
    localparam int BEAT_W     = 128;
    localparam int BEAT_BYTES = 16;
    localparam int LINE_OFS_W = 6;
    localparam int CNT_W      = 3;

    typedef enum logic [2:0] {
        WB_IDLE,
        WB_RD,
        WB_AW,
        WB_W,
        WB_B
    } wback_state_e;

endpackage

// File: rtl/dcache_wback_line_buf.sv
// Victim line staging buffer: 4 x 128 b, one write port (capture) and one read port (W beat).
module dcache_wback_line_buf
    import dcache_pkg::*;
(
    input  logic                clock,
    input  logic                wr_en,
    input  logic [OFFSET_W-1:0] wr_idx,
    input  logic [BEAT_W-1:0]   wr_data,
    input  logic [OFFSET_W-1:0] rd_idx,
    output logic [BEAT_W-1:0]   rd_data
);

    logic [BEAT_W-1:0] mem [LINE_BEATS];

    // NOTE: storage has no reset; every entry is rewritten before the burst that reads it.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/dcache_wback.sv
// Dirty-line writeback engine: reads a victim line from the data array, then writes it as one 4-beat burst.
// Optional B-response error flag enabled by defining DCACHE_WBACK_RESP_CHK_EN.
module dcache_wback
    import dcache_pkg::*;
#(
    parameter int TAG_W  = 20,
    parameter int ADDR_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wback_req_valid,
    output logic                wback_req_ready,
    input  logic [INDEX_W-1:0]  wback_req_index,
    input  logic [WAY_W-1:0]    wback_req_way,
    input  logic [TAG_W-1:0]    wback_req_tag,
    output logic                wback_busy,
    output logic                wback_done,
    input  logic                wback_array_gnt,
    output logic                wback2data_array_valid,
    output logic [INDEX_W-1:0]  wback2data_array_index,
    output logic [WAY_W-1:0]    wback2data_array_way,
    output logic [OFFSET_W-1:0] wback2data_array_offset,
    output logic                wback2data_array_ready,
    input  logic [BEAT_W-1:0]   data_array2wback_rdata,
    output logic                mem_aw_valid,
    input  logic                mem_aw_ready,
    output logic [ADDR_W-1:0]   mem_aw_addr,
    output logic                mem_w_valid,
    input  logic                mem_w_ready,
    output logic [BEAT_W-1:0]   mem_w_data,
    output logic                mem_w_last,
    input  logic                mem_b_valid,
`ifdef DCACHE_WBACK_RESP_CHK_EN
    input  logic [1:0]          mem_b_resp,
    output logic                wback_err,
`endif
    output logic                mem_b_ready
);

    wback_state_e        state;
    logic [INDEX_W-1:0]  index_q;
    logic [WAY_W-1:0]    way_q;
    logic [TAG_W-1:0]    tag_q;
    logic [CNT_W-1:0]    issue_cnt;
    logic [CNT_W-1:0]    cap_cnt;
    logic                cap_pend;
    logic [OFFSET_W-1:0] beat;
    logic                req_ready_q;
    logic                done_q;
    logic                aw_valid_q;
    logic                w_valid_q;
    logic                b_ready_q;
    logic                rd_strobe;
    logic [BEAT_W-1:0]   buf_rdata;
`ifdef DCACHE_WBACK_RESP_CHK_EN
    logic                err_q;
`endif

    // At most one captured-but-unread beat may be outstanding, so the array holder never gets overrun.
    assign rd_strobe = (state == WB_RD) && wback_array_gnt
                    && (issue_cnt < CNT_W'(LINE_BEATS))
                    && ((issue_cnt - cap_cnt) <= CNT_W'(1));

    // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= WB_IDLE;
            index_q     <= '0;
            way_q       <= '0;
            tag_q       <= '0;
            issue_cnt   <= '0;
            cap_cnt     <= '0;
            cap_pend    <= 1'b0;
            beat        <= '0;
            req_ready_q <= 1'b0;
            done_q      <= 1'b0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            b_ready_q   <= 1'b0;
`ifdef DCACHE_WBACK_RESP_CHK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            done_q   <= 1'b0;
            cap_pend <= rd_strobe;
            if (rd_strobe) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
            if (cap_pend) begin
                cap_cnt <= cap_cnt + CNT_W'(1);
            end

            case (state)
                WB_IDLE: begin
                    // Ready stays low in the done cycle, so a new request lands no earlier than the one after.
                    if (wback_req_valid && req_ready_q) begin
                        index_q     <= wback_req_index;
                        way_q       <= wback_req_way;
                        tag_q       <= wback_req_tag;
                        issue_cnt   <= '0;
                        cap_cnt     <= '0;
                        req_ready_q <= 1'b0;
                        state       <= WB_RD;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                WB_RD: begin
                    if (cap_pend && (cap_cnt == CNT_W'(LINE_BEATS - 1))) begin
                        aw_valid_q <= 1'b1;
                        state      <= WB_AW;
                    end
                end
                WB_AW: begin
                    if (mem_aw_ready) begin
                        aw_valid_q <= 1'b0;
                        w_valid_q  <= 1'b1;
                        beat       <= '0;
                        state      <= WB_W;
                    end
                end
                WB_W: begin
                    if (mem_w_ready) begin
                        beat <= beat + OFFSET_W'(1);
                        if (beat == OFFSET_W'(LINE_BEATS - 1)) begin
                            w_valid_q <= 1'b0;
                            b_ready_q <= 1'b1;
                            state     <= WB_B;
                        end
                    end
                end
                WB_B: begin
                    if (mem_b_valid) begin
                        b_ready_q <= 1'b0;
                        done_q    <= 1'b1;
                        state     <= WB_IDLE;
`ifdef DCACHE_WBACK_RESP_CHK_EN
                        if (mem_b_resp != 2'b00) begin
                            err_q <= 1'b1;
                        end
`endif
                    end
                end
                default: state <= WB_IDLE;
            endcase
        end
    end

    dcache_wback_line_buf u_line_buf (
        .clock   (clock),
        .wr_en   (cap_pend),
        .wr_idx  (cap_cnt[OFFSET_W-1:0]),
        .wr_data (data_array2wback_rdata),
        .rd_idx  (beat),
        .rd_data (buf_rdata)
    );

    assign wback_req_ready         = req_ready_q;
    assign wback_busy              = (state != WB_IDLE);
    assign wback_done              = done_q;
    assign wback2data_array_valid  = rd_strobe;
    assign wback2data_array_index  = index_q;
    assign wback2data_array_way    = way_q;
    assign wback2data_array_offset = issue_cnt[OFFSET_W-1:0];
    assign wback2data_array_ready  = cap_pend;
    assign mem_aw_valid            = aw_valid_q;
    assign mem_aw_addr             = ADDR_W'({tag_q, index_q, {LINE_OFS_W{1'b0}}});
    assign mem_w_valid             = w_valid_q;
    assign mem_w_data              = w_valid_q ? buf_rdata : '0;
    assign mem_w_last              = w_valid_q && (beat == OFFSET_W'(LINE_BEATS - 1));
    assign mem_b_ready             = b_ready_q;
`ifdef DCACHE_WBACK_RESP_CHK_EN
    assign wback_err               = err_q;
`endif

endmodule

// File: tb/tb_dcache_wback.sv
// Randomized self-checking bench for dcache_wback against a transaction-level line/burst model.
module tb_dcache_wback;

    localparam int TAG_W       = 20;
    localparam int ADDR_W      = 32;
    localparam int TXN_TIMEOUT = 200;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              wback_req_valid;
    logic              wback_req_ready;
    logic [5:0]        wback_req_index;
    logic [2:0]        wback_req_way;
    logic [TAG_W-1:0]  wback_req_tag;
    logic              wback_busy;
    logic              wback_done;
    logic              wback_array_gnt;
    logic              wback2data_array_valid;
    logic [5:0]        wback2data_array_index;
    logic [2:0]        wback2data_array_way;
    logic [1:0]        wback2data_array_offset;
    logic              wback2data_array_ready;
    logic [127:0]      data_array2wback_rdata = '0;
    logic              mem_aw_valid;
    logic              mem_aw_ready;
    logic [ADDR_W-1:0] mem_aw_addr;
    logic              mem_w_valid;
    logic              mem_w_ready;
    logic [127:0]      mem_w_data;
    logic              mem_w_last;
    logic              mem_b_valid;
    logic              mem_b_ready;
`ifdef DCACHE_WBACK_RESP_CHK_EN
    logic [1:0]        mem_b_resp;
    logic              wback_err;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int prev_done_cyc = -100;
    logic [127:0] line_data [4];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Data array model: beat presented the cycle after a strobe, held until the next strobe.
    always @(posedge clock) begin
        if (wback2data_array_valid) begin
            data_array2wback_rdata <= line_data[wback2data_array_offset];
        end
    end

    dcache_wback #(.TAG_W(TAG_W), .ADDR_W(ADDR_W)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .wback_req_valid         (wback_req_valid),
        .wback_req_ready         (wback_req_ready),
        .wback_req_index         (wback_req_index),
        .wback_req_way           (wback_req_way),
        .wback_req_tag           (wback_req_tag),
        .wback_busy              (wback_busy),
        .wback_done              (wback_done),
        .wback_array_gnt         (wback_array_gnt),
        .wback2data_array_valid  (wback2data_array_valid),
        .wback2data_array_index  (wback2data_array_index),
        .wback2data_array_way    (wback2data_array_way),
        .wback2data_array_offset (wback2data_array_offset),
        .wback2data_array_ready  (wback2data_array_ready),
        .data_array2wback_rdata  (data_array2wback_rdata),
        .mem_aw_valid            (mem_aw_valid),
        .mem_aw_ready            (mem_aw_ready),
        .mem_aw_addr             (mem_aw_addr),
        .mem_w_valid             (mem_w_valid),
        .mem_w_ready             (mem_w_ready),
        .mem_w_data              (mem_w_data),
        .mem_w_last              (mem_w_last),
        .mem_b_valid             (mem_b_valid),
`ifdef DCACHE_WBACK_RESP_CHK_EN
        .mem_b_resp              (mem_b_resp),
        .wback_err               (wback_err),
`endif
        .mem_b_ready             (mem_b_ready)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, {wback_req_ready, wback_busy, wback_done, wback2data_array_valid,
                               wback2data_array_ready, mem_aw_valid, mem_w_valid, mem_w_last,
                               mem_b_ready}, 9'd0);
        check({tag, "_w_data"}, mem_w_data, 128'd0);
        check({tag, "_aw_addr"}, mem_aw_addr, 32'd0);
        check({tag, "_array_sel"}, {wback2data_array_index, wback2data_array_way,
                                    wback2data_array_offset}, 11'd0);
    endtask

    // Reset in the middle of a burst: outputs drop at once, engine comes back idle and silent.
    task automatic reset_mid_burst();
        bit stray = 1'b0;
        reset = 1'b0;
        #1;
        check_outputs_zero("rst_async");
        wback_req_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        check("post_rst_req_ready", wback_req_ready, 1'b1);
        check("post_rst_busy", wback_busy, 1'b0);
        repeat (10) begin
            @(negedge clock);
            if (mem_aw_valid || mem_w_valid || wback2data_array_valid) stray = 1'b1;
        end
        check("post_rst_no_stray", stray, 1'b0);
    endtask

    // mode: 0 clean, 1 gnt low 3 cycles after second strobe, 2 w_ready toggles, 3 random
    task automatic run_txn(input logic [5:0] idx, input logic [2:0] way, input logic [TAG_W-1:0] tag,
                           input int mode, input bit keep_data, input bit hold_valid,
                           input bit timing_chk, input bit b2b_chk, input bit rst_at_w2);
        int n_st = 0, n_cap = 0, n_aw = 0, n_w = 0;
        int acc_cyc = -1, first_st = -1, last_st = -1, aw_cyc = -1, last_w_cyc = -1, done_cyc = -1;
        int stall_left = 3, stall_cap = 0;
        bit accepted = 1'b0, finished = 1'b0, wtog = 1'b0;
        logic [ADDR_W-1:0] exp_addr;
        exp_addr = {tag, idx, 6'b0};
        if (!keep_data) begin
            for (int b = 0; b < 4; b++) line_data[b] = {$urandom, $urandom, $urandom, $urandom};
        end

        for (int c = 0; c < TXN_TIMEOUT && !finished; c++) begin
            @(posedge clock);
            #1;
            wback_req_index = idx;
            wback_req_way   = way;
            wback_req_tag   = tag;
            wback_req_valid = accepted ? hold_valid : 1'b1;
            wback_array_gnt = 1'b1;
            mem_aw_ready    = 1'b1;
            mem_w_ready     = 1'b1;
            mem_b_valid     = 1'b1;
            case (mode)
                1: begin
                    if (n_st >= 2 && stall_left > 0) begin
                        wback_array_gnt = 1'b0;
                        stall_left--;
                    end
                end
                2: begin
                    mem_w_ready = wtog;
                    wtog = !wtog;
                end
                3: begin
                    wback_array_gnt = ($urandom_range(0, 3) != 0);
                    mem_aw_ready    = $urandom_range(0, 1) == 1;
                    mem_w_ready     = $urandom_range(0, 1) == 1;
                    mem_b_valid     = $urandom_range(0, 1) == 1;
                end
                default: ;
            endcase

            @(negedge clock);
            if (rst_at_w2 && mem_w_valid && n_w == 2) begin
                reset_mid_burst();
                return;
            end
            if (!accepted && wback_req_valid && wback_req_ready) begin
                accepted = 1'b1;
                acc_cyc  = cyc;
                if (b2b_chk) check("b2b_accept_cycle", acc_cyc, prev_done_cyc + 1);
            end
            if (wback_busy) check("req_ready_busy", wback_req_ready, 1'b0);
            if (!wback_array_gnt) begin
                check("strobe_gnt_low", wback2data_array_valid, 1'b0);
                if (wback2data_array_ready) stall_cap++;
            end
            if (wback2data_array_valid) begin
                if (n_st < 4) check("strobe_offset", wback2data_array_offset, n_st[1:0]);
                else check("strobe_extra", 1'b1, 1'b0);
                check("strobe_index", wback2data_array_index, idx);
                check("strobe_way", wback2data_array_way, way);
                if (n_st == 0) first_st = cyc;
                last_st = cyc;
                n_st++;
            end
            if (wback2data_array_ready) n_cap++;
            if (mem_aw_valid) begin
                if (aw_cyc < 0) aw_cyc = cyc;
                if (mem_aw_ready) begin
                    check("aw_addr", mem_aw_addr, exp_addr);
                    n_aw++;
                end
            end
            if (mem_w_valid) begin
                if (n_aw == 0) check("w_before_aw", 1'b1, 1'b0);
                if (n_w < 4) begin
                    check("w_data", mem_w_data, line_data[n_w]);
                    check("w_last", mem_w_last, n_w == 3);
                end else begin
                    check("w_extra", 1'b1, 1'b0);
                end
                if (mem_w_ready) begin
                    n_w++;
                    last_w_cyc = cyc;
                end
            end
            if (wback_done) begin
                done_cyc = cyc;
                finished = 1'b1;
                check("req_ready_at_done", wback_req_ready, 1'b0);
            end
        end

        if (!finished) begin
            check("txn_timeout", 1'b0, 1'b1);
            return;
        end
        check("n_strobes", n_st, 4);
        check("n_captures", n_cap, 4);
        check("n_aw", n_aw, 1);
        check("n_w", n_w, 4);
        prev_done_cyc = done_cyc;
        if (mode == 1) check("capture_during_stall", stall_cap, 1);
        if (timing_chk) begin
            check("first_strobe_lat", first_st - acc_cyc, 1);
            check("last_strobe_lat", last_st - acc_cyc, 4);
            check("aw_lat", aw_cyc - acc_cyc, 6);
            check("done_after_last_w", done_cyc - last_w_cyc, 2);
        end
    endtask

    initial begin
        bit extra_done = 1'b0;
        wback_req_valid = 1'b0;
        wback_req_index = '0;
        wback_req_way   = '0;
        wback_req_tag   = '0;
        wback_array_gnt = 1'b0;
        mem_aw_ready    = 1'b0;
        mem_w_ready     = 1'b0;
        mem_b_valid     = 1'b0;
`ifdef DCACHE_WBACK_RESP_CHK_EN
        mem_b_resp      = 2'b00;
`endif

        repeat (2) @(negedge clock);
        check_outputs_zero("in_reset");
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("ready_after_reset", wback_req_ready, 1'b1);
        check("busy_after_reset", wback_busy, 1'b0);
`ifdef DCACHE_WBACK_RESP_CHK_EN
        check("err_after_reset", wback_err, 1'b0);
`endif

        // Stall-free reference run, then the same line under a grant stall and a choppy W channel.
        run_txn(6'h2A, 3'd5, 20'hABCDE, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_txn(6'h2A, 3'd5, 20'hABCDE, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_txn(6'h15, 3'd2, 20'h12345, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Request held high through completion, next one taken the cycle after done.
        run_txn(6'h01, 3'd7, 20'hFFFFF, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_txn(6'h3F, 3'd0, 20'h00000, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        for (int t = 0; t < 25; t++) begin
            run_txn(6'($urandom), 3'($urandom), TAG_W'($urandom), 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        run_txn(6'h0C, 3'd3, 20'h5A5A5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_txn(6'h22, 3'd4, 20'h0BEEF, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef DCACHE_WBACK_RESP_CHK_EN
        mem_b_resp = 2'b10;
        run_txn(6'h10, 3'd1, 20'hC0FFE, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        check("err_on_slverr", wback_err, 1'b1);
        mem_b_resp = 2'b00;
        run_txn(6'h11, 3'd6, 20'h13579, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        check("err_sticky_after_okay", wback_err, 1'b1);
`endif

        wback_req_valid = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (wback_done) extra_done = 1'b1;
        end
        check("no_extra_done", extra_done, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_wback.md
Name: dcache_wback

Overview:
- Dirty-line writeback engine of the dcache, directly downstream of the data array's wback read port.
- On a request from the replace/miss controller it reads the 4 beats (4 x 128 b = 64 B) of the victim line through the data array's wback interface and collects them in an internal line buffer.
- It then issues one 4-beat incrementing burst on the memory write channel and reports completion.

Parameters:
- TAG_W, 20, victim tag width; address = {tag, index[5:0], 6'b0}
- ADDR_W, 32, memory address width; equals TAG_W+12

Ports:
- clock  in  1  single clock
- reset  in  1  asynchronous, active-low reset
- wback_req_valid  in  1  writeback request
- wback_req_ready  out  1  high only in IDLE
- wback_req_index  in  6  victim set
- wback_req_way  in  3  victim way
- wback_req_tag  in  TAG_W  victim tag
- wback_busy  out  1  state != IDLE
- wback_done  out  1  one-cycle pulse on B handshake
- wback_array_gnt  in  1  arbiter grant; no hit_read/hit_write/fill access to the array this cycle
- wback2data_array_valid  out  1  beat read strobe
- wback2data_array_index  out  6  latched index
- wback2data_array_way  out  3  latched way
- wback2data_array_offset  out  2  beat number
- wback2data_array_ready  out  1  capture acknowledge to the array's data holder
- data_array2wback_rdata  in  128  beat data, valid the cycle after a strobe and held until ready
- mem_aw_valid  out  1  write address valid
- mem_aw_ready  in  1  write address accepted
- mem_aw_addr  out  ADDR_W  burst start address
- mem_w_valid  out  1  write data valid
- mem_w_ready  in  1  write data accepted
- mem_w_data  out  128  write beat data
- mem_w_last  out  1  last beat of burst
- mem_b_valid  in  1  write response valid
- mem_b_ready  out  1  write response accepted

Behaviour:
- Reset (async, active-low): state=IDLE; all valid/ready/done/busy outputs 0; counters 0; wback_req_ready=1 once reset deasserts. Reset mid-burst aborts the burst silently; upstream re-issues.
- IDLE:
  - On req_valid&&req_ready, latch index/way/tag; issue_cnt=0, cap_cnt=0.
  - Next state RD.
- RD:
  - Strobe: wback2data_array_valid = gnt && issue_cnt<4 && (issue_cnt-cap_cnt)<=1.
  - offset = issue_cnt; issue_cnt increments on each strobe.
  - In the cycle after a strobe, wback2data_array_ready=1; rdata is written into buf[cap_cnt] and cap_cnt increments.
  - Back-to-back strobes allowed, so the best case is 4 strobes in 4 cycles plus 1 capture cycle.
  - gnt low suppresses the strobe only; a capture already in flight still completes, because the array holds its data.
  - cap_cnt==4 -> AW.
- AW:
  - mem_aw_valid=1, addr={tag,index,6'b0}; burst is 4 beats x 16 B, INCR, full strobes.
  - Handshake -> W, beat=0.
- W:
  - mem_w_valid=1, mem_w_data=buf[beat], mem_w_last=(beat==3).
  - Each handshake increments beat; handshake with last -> B.
  - Data and valid stay stable while ready is low.
- B:
  - mem_b_ready=1; mem_b_valid -> wback_done=1 for one cycle, next state IDLE.
  - A new request is accepted no earlier than the cycle after done.
- Widths: issue_cnt and cap_cnt are 3 b (0..4); beat is 2 b.
- The array interface never sees offset beyond 3. Index and way are constant for the whole request.
- wback2data_array_valid is never high outside RD.
- Latency with no stalls: req accepted at cycle 0, AW valid at cycle 6, done 2 cycles after the last W handshake.

Optional Feature:
- Macro DCACHE_WBACK_RESP_CHK_EN.
- Defined:
  - Adds input mem_b_resp[1:0] and output wback_err.
  - wback_err is sticky: set when a B handshake has resp!=2'b00, cleared only by reset. wback_done still pulses.
- Undefined: neither port exists; any response is treated as OKAY.

Decomposition:
- Package dcache_pkg: INDEX_W=6, WAY_W=3, OFFSET_W=2, LINE_BEATS=4, BEAT_W=128, BEAT_BYTES=16, wback state encoding (IDLE, RD, AW, W, B).
- Sub-module dcache_wback_line_buf: 4x128 register file, one write port indexed by cap_cnt, one read port indexed by beat.

Test Plan:
- Req index=6'h2A, way=5, tag=20'hABCDE, gnt=1, aw/w/b ready=1:
  - offsets 0,1,2,3 on consecutive cycles
  - aw_addr=32'hABCDEA80
  - W data equals the array contents of beats 0..3; last on beat 3
  - done pulses once
- gnt low for 3 cycles after the second strobe:
  - no strobe while gnt is low
  - the second beat is still captured
  - remaining beats resume; W data is unchanged versus the stall-free run
- mem_w_ready toggling 0/1 every cycle:
  - data/last stay stable while ready=0
  - exactly 4 W handshakes
- wback_req_valid held high through completion:
  - req_ready=0 while busy
  - second request accepted the cycle after done
- Assert reset during W beat 2:
  - all outputs 0 immediately
  - after release: IDLE, req_ready=1, no stray AW or W
- DCACHE_WBACK_RESP_CHK_EN defined, mem_b_resp=2'b10:
  - wback_err=1 and stays 1 after a following OKAY transfer
  - done still pulses
